instr_encoder: RTL

- Writer-side counterpart to the control decoder: takes decoded instruction fields over a valid/ready handshake, packs them into 9-bit machine words `{op[2:0], a[2:0], b[2:0]}`, and writes them sequentially into instruction memory starting at address 0.
- Used by the test/boot path to load programs that the fetch/decode path later executes.
- Tracks program length, end-of-program and memory-full conditions.

---
 rtl/instr_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields {op, a, b} into machine words
// and writes them sequentially into instruction memory from address 0.
// Tracks program length, end-of-program and memory-full conditions.
module instr_encoder #(
  parameter int OPW   = 3,
  parameter int FW    = 3,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPW-1:0]        in_op,
  input  logic [FW-1:0]         in_a,
  input  logic [FW-1:0]         in_b,
  input  logic                  in_last,
  output logic                  im_we,
  output logic [AW-1:0]         im_addr,
  output logic [OPW+2*FW-1:0]   im_wdata,
  output logic [AW:0]           prog_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err_full
);

  localparam int WW = OPW + 2 * FW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err_full;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_wr_ptr;
  logic [WW-1:0]   r_wdata;
  logic [AW:0]     r_prog_len;

  logic            w_accept;
  logic            w_at_end;

  // A field set is taken only while the encoder advertises ready (LOAD state).
  assign w_accept = in_valid & r_in_ready;
  // Writing the last memory slot ends the load whether or not in_last is set.
  assign w_at_end = (r_wr_ptr == LAST_ADDR);

  // Load FSM with all outputs registered; the write strobe is a one-cycle pulse.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the synchronous reset lives in the same clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_full <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wr_ptr   <= '0;
      r_wdata    <= '0;
      r_prog_len <= '0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err_full <= 1'b0;
            r_wr_ptr   <= '0;
            r_addr     <= '0;
            r_prog_len <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we       <= 1'b1;
            r_addr     <= r_wr_ptr;
            r_wdata    <= {in_op, in_a, in_b};
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_prog_len <= r_prog_len + 1'b1;
            if (in_last || w_at_end) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_err_full <= ~in_last;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err_full = r_err_full;
  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign prog_len = r_prog_len;

endmodule
